// File: rtl/bit_replay.sv
// bit_replay: packs host bytes into 16-bit words in a block RAM and
// replays them as a serial bitstream, MSB of each word first.
//
// Ports:
//   i_clk        system clock
//   i_rst        asynchronous active-low reset
//   i_load       pulse, start a new load session (clears words/overflow)
//   i_byte_in    data byte, valid with i_byte_stb
//   i_byte_stb   byte strobe, only honoured in LOAD
//   i_play       pulse, start playback (needs at least one stored word)
//   i_loop       sampled with i_play: 1 = repeat, 0 = one-shot
//   i_stop       abort load or playback
//   o_sig_out    replayed bitstream, 0 when not playing
//   o_busy       high while playing
//   o_done       one-cycle pulse at the end of a one-shot playback
//   o_words      number of complete words stored
//   o_overflow   sticky, a byte arrived while memory was full
module bit_replay #(
    parameter int DIV = 1,
    parameter int AW  = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [7:0]    i_byte_in,
    input  logic          i_byte_stb,
    input  logic          i_play,
    input  logic          i_loop,
    input  logic          i_stop,
    output logic          o_sig_out,
    output logic          o_busy,
    output logic          o_done,
    output logic [AW:0]   o_words,
    output logic          o_overflow
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [AW:0]   W_ONE    = (AW + 1)'(1);
    localparam logic [AW-1:0] A_ONE    = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY
    } state_t;

    state_t        r_state;
    logic [AW:0]   r_words;
    logic          r_ovf;
    logic          r_half;
    logic [7:0]    r_hold;
    logic [AW-1:0] r_raddr;
    logic [AW-1:0] r_widx;
    logic [15:0]   r_rdata;
    logic [15:0]   r_sr;
    logic [DW-1:0] r_div;
    logic [3:0]    r_bit;
    logic [1:0]    r_warm;
    logic          r_loop;
    logic          r_busy;
    logic          r_done;

    logic [15:0]   r_mem [0:(2**AW)-1];

    logic [AW:0]   w_last;
    logic [AW-1:0] w_raddr_next;
    logic          w_widx_last;
    logic          w_full;
    logic          w_play_go;
    logic          w_stb_ok;
    logic          w_we;

    assign w_last       = r_words - W_ONE;
    // Prefetch address wraps to 0 after the last stored word.
    assign w_raddr_next = ({1'b0, r_raddr} == w_last) ? '0 : r_raddr + A_ONE;
    assign w_widx_last  = ({1'b0, r_widx} == w_last);
    assign w_full       = r_words[AW];
    assign w_play_go    = i_play && (r_words != '0);
    // Commands outrank a strobe arriving in the same cycle.
    assign w_stb_ok     = (r_state == S_LOAD) && i_byte_stb && !i_stop
                          && !i_load && !w_play_go;
    assign w_we         = w_stb_ok && !w_full && r_half;

    // Block RAM: synchronous write, registered read, no reset.
    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[r_words[AW-1:0]] <= {r_hold, i_byte_in};
        end
        r_rdata <= r_mem[r_raddr];
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_words <= '0;
            r_ovf   <= 1'b0;
            r_half  <= 1'b0;
            r_hold  <= '0;
            r_raddr <= '0;
            r_widx  <= '0;
            r_sr    <= '0;
            r_div   <= '0;
            r_bit   <= '0;
            r_warm  <= '0;
            r_loop  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_stop) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_sr    <= '0;
                r_half  <= 1'b0;
            end else if (i_load) begin
                r_state <= S_LOAD;
                r_busy  <= 1'b0;
                r_sr    <= '0;
                r_words <= '0;
                r_ovf   <= 1'b0;
                r_half  <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE, S_LOAD: begin
                        if (w_play_go) begin
                            r_state <= S_PLAY;
                            r_busy  <= 1'b1;
                            r_loop  <= i_loop;
                            r_raddr <= '0;
                            r_warm  <= 2'd2;
                            r_div   <= '0;
                            r_bit   <= '0;
                            r_sr    <= '0;
                            r_half  <= 1'b0;
                        end else if (w_stb_ok) begin
                            if (w_full) begin
                                r_ovf <= 1'b1;
                            end else if (!r_half) begin
                                r_hold <= i_byte_in;
                                r_half <= 1'b1;
                            end else begin
                                r_words <= r_words + W_ONE;
                                r_half  <= 1'b0;
                            end
                        end
                    end
                    S_PLAY: begin
                        if (r_warm == 2'd2) begin
                            // Word 0 is being read; queue word 1.
                            r_warm  <= 2'd1;
                            r_raddr <= w_raddr_next;
                        end else if (r_warm == 2'd1) begin
                            r_warm <= 2'd0;
                            r_sr   <= r_rdata;
                            r_div  <= '0;
                            r_bit  <= '0;
                            r_widx <= '0;
                        end else if (r_div != DIV_LAST) begin
                            r_div <= r_div + DIV_ONE;
                        end else begin
                            r_div <= '0;
                            if (r_bit != 4'd15) begin
                                r_bit <= r_bit + 4'd1;
                                r_sr  <= {r_sr[14:0], 1'b0};
                            end else if (w_widx_last && !r_loop) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                                r_sr    <= '0;
                                r_done  <= 1'b1;
                            end else begin
                                // Prefetched word is already in r_rdata.
                                r_sr    <= r_rdata;
                                r_bit   <= '0;
                                r_widx  <= r_raddr;
                                r_raddr <= w_raddr_next;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_sig_out  = r_sr[15];
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_words    = r_words;
    assign o_overflow = r_ovf;

endmodule

// File: tb/tb_bit_replay.sv
// tb_bit_replay: directed bench for bit_replay with three instances
// (DIV=1/AW=8, DIV=3/AW=8, DIV=1/AW=2) sharing one stimulus.
module tb_bit_replay;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] bin;
    logic       stb;
    logic       play;
    logic       loop_i;
    logic       stop;

    logic       s0, b0, d0, o0;
    logic [8:0] w0;
    logic       s1, b1, d1, o1;
    logic [8:0] w1;
    logic       s2, b2, d2, o2;
    logic [2:0] w2;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bit_replay #(.DIV(1), .AW(8)) u0 (
        .i_clk(clk), .i_rst(rst), .i_load(load), .i_byte_in(bin),
        .i_byte_stb(stb), .i_play(play), .i_loop(loop_i), .i_stop(stop),
        .o_sig_out(s0), .o_busy(b0), .o_done(d0), .o_words(w0),
        .o_overflow(o0)
    );

    bit_replay #(.DIV(3), .AW(8)) u1 (
        .i_clk(clk), .i_rst(rst), .i_load(load), .i_byte_in(bin),
        .i_byte_stb(stb), .i_play(play), .i_loop(loop_i), .i_stop(stop),
        .o_sig_out(s1), .o_busy(b1), .o_done(d1), .o_words(w1),
        .o_overflow(o1)
    );

    bit_replay #(.DIV(1), .AW(2)) u2 (
        .i_clk(clk), .i_rst(rst), .i_load(load), .i_byte_in(bin),
        .i_byte_stb(stb), .i_play(play), .i_loop(loop_i), .i_stop(stop),
        .o_sig_out(s2), .o_busy(b2), .o_done(d2), .o_words(w2),
        .o_overflow(o2)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig_of(input int sel);
        case (sel)
            0:       return s0;
            1:       return s1;
            default: return s2;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            0:       return b0;
            1:       return b1;
            default: return b2;
        endcase
    endfunction

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return d0;
            1:       return d1;
            default: return d2;
        endcase
    endfunction

    task automatic send(input logic [7:0] b);
        bin = b;
        stb = 1'b1;
        step;
        stb = 1'b0;
    endtask

    task automatic pulse_load;
        load = 1'b1;
        step;
        load = 1'b0;
    endtask

    task automatic pulse_play(input logic l);
        play   = 1'b1;
        loop_i = l;
        step;
        play   = 1'b0;
        loop_i = 1'b0;
    endtask

    // One-shot playback at DIV=1: bit k expected at E+2+k, done at E+2+n.
    task automatic oneshot(input int sel, input logic [63:0] pat,
                           input int nbits, input string tag);
        pulse_play(1'b0);
        chk({tag, "_busy_E"}, 32'(busy_of(sel)), 32'd1);
        chk({tag, "_sig_E"}, 32'(sig_of(sel)), 32'd0);
        step;
        chk({tag, "_sig_E1"}, 32'(sig_of(sel)), 32'd0);
        for (int i = 0; i < nbits; i++) begin
            step;
            chk({tag, "_bit"}, 32'(sig_of(sel)), 32'(pat[nbits-1-i]));
            chk({tag, "_busy"}, 32'(busy_of(sel)), 32'd1);
            chk({tag, "_nodone"}, 32'(done_of(sel)), 32'd0);
        end
        step;
        chk({tag, "_done"}, 32'(done_of(sel)), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy_of(sel)), 32'd0);
        chk({tag, "_sig_end"}, 32'(sig_of(sel)), 32'd0);
        step;
        chk({tag, "_done_once"}, 32'(done_of(sel)), 32'd0);
    endtask

    logic [31:0] pat2;
    logic [7:0]  bv [10];

    initial begin
        rst    = 1'b0;
        load   = 1'b0;
        bin    = 8'h00;
        stb    = 1'b0;
        play   = 1'b0;
        loop_i = 1'b0;
        stop   = 1'b0;
        pat2   = 32'hF00F_8118;
        bv     = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                   8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};

        // reset state
        #12;
        chk("rst_sig", 32'(s0), 32'd0);
        chk("rst_busy", 32'(b0), 32'd0);
        chk("rst_done", 32'(d0), 32'd0);
        chk("rst_words", 32'(w0), 32'd0);
        chk("rst_ovf", 32'(o0), 32'd0);
        step;
        step;
        rst = 1'b1;
        step;

        // one word, one-shot, DIV=1
        pulse_load;
        send(8'hA5);
        chk("t1_words_half", 32'(w0), 32'd0);
        send(8'h3C);
        chk("t1_words", 32'(w0), 32'd1);
        oneshot(0, 64'hA53C, 16, "t1");

        // two words, loop, DIV=3, then stop mid-word
        pulse_load;
        send(8'hF0);
        send(8'h0F);
        send(8'h81);
        send(8'h18);
        chk("t2_words", 32'(w1), 32'd2);
        pulse_play(1'b1);
        chk("t2_busy_E", 32'(b1), 32'd1);
        step;
        chk("t2_sig_E1", 32'(s1), 32'd0);
        for (int c = 0; c <= 200; c++) begin
            step;
            chk("t2_bit", 32'(s1), 32'(pat2[31 - ((c / 3) % 32)]));
            chk("t2_nodone", 32'(d1), 32'd0);
        end
        chk("t2_busy_mid", 32'(b1), 32'd1);
        stop = 1'b1;
        step;
        stop = 1'b0;
        chk("t2_stop_sig", 32'(s1), 32'd0);
        chk("t2_stop_busy", 32'(b1), 32'd0);
        chk("t2_stop_done", 32'(d1), 32'd0);
        chk("t2_stop_words", 32'(w1), 32'd2);
        step;
        chk("t2_stop_done2", 32'(d1), 32'd0);

        // dangling half-word discarded
        pulse_load;
        send(8'hFF);
        send(8'h00);
        send(8'hAA);
        chk("t3_words", 32'(w0), 32'd1);
        oneshot(0, 64'hFF00, 16, "t3");

        // overflow on the AW=2 instance
        pulse_load;
        for (int i = 0; i < 10; i++) begin
            send(bv[i]);
            if (i == 7) chk("t4_ovf_pre", 32'(o2), 32'd0);
            if (i == 8) chk("t4_ovf_set", 32'(o2), 32'd1);
        end
        chk("t4_words", 32'(w2), 32'd4);
        chk("t4_ovf", 32'(o2), 32'd1);
        chk("t4_words_big", 32'(w0), 32'd5);
        chk("t4_ovf_big", 32'(o0), 32'd0);
        oneshot(2, 64'h1122_3344_5566_7788, 64, "t4");

        // async reset during u0 playback (word 4 = 99AA)
        step;
        step;
        chk("t5_busy_pre", 32'(b0), 32'd1);
        chk("t5_sig_pre", 32'(s0), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_rst_sig", 32'(s0), 32'd0);
        chk("t5_rst_busy", 32'(b0), 32'd0);
        chk("t5_rst_words", 32'(w0), 32'd0);
        chk("t5_rst_sig1", 32'(s1), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step;
        pulse_play(1'b0);
        chk("t5_play_busy", 32'(b0), 32'd0);
        chk("t5_play_done", 32'(d0), 32'd0);
        step;
        step;
        chk("t5_play_busy2", 32'(b0), 32'd0);
        chk("t5_play_done2", 32'(d0), 32'd0);

        // load + play together during PLAY: load wins
        pulse_load;
        send(8'h12);
        send(8'h34);
        pulse_play(1'b1);
        chk("t6_busy", 32'(b0), 32'd1);
        step;
        step;
        step;
        load = 1'b1;
        play = 1'b1;
        step;
        load = 1'b0;
        play = 1'b0;
        chk("t6_busy_off", 32'(b0), 32'd0);
        chk("t6_words", 32'(w0), 32'd0);
        chk("t6_sig", 32'(s0), 32'd0);
        send(8'h56);
        send(8'h78);
        chk("t6_in_load", 32'(w0), 32'd1);
        chk("t6_busy_load", 32'(b0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
